mult_div_unit: RTL
==================

Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the MIPS datapath, directly downstream of the register file.
- Consumes read_data1 (rs) and read_data2 (rt) and implements MULT, MULTU, DIV, DIVU, MTHI and MTLO into private HI/LO registers.
- Exposes HI/LO to the MFHI/MFLO path and drives busy, which the pipeline controller uses as a stall source.
- One operation in flight at a time, fixed latency.

Parameters:
- WIDTH, 32, operand width; HI and LO are each WIDTH bits.
- CNT_W, 6, iteration-counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- start  input  1  launch the operation selected by op; sampled only in IDLE.
- op  input  2  operation select: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- rs_data  input  WIDTH  rs operand: multiplicand or dividend; also the MTHI/MTLO source.
- rt_data  input  WIDTH  rt operand: multiplier or divisor.
- write_hi  input  1  MTHI: HI <= rs_data.
- write_lo  input  1  MTLO: LO <= rs_data.
- busy  output  1  operation in progress; the pipeline stalls on MFHI/MFLO while this is high.
- done  output  1  single-cycle pulse when the result is written to HI/LO.
- hi  output  WIDTH  HI register: product upper half, or remainder.
- lo  output  WIDTH  LO register: product lower half, or quotient.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n); it is sampled only on the rising edge of clk.
- Reset values: hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0.
- Reset mid-operation aborts the operation: all outputs return to their reset values on that edge and no partial result is written.
- States:
  - IDLE: accept start/write_hi/write_lo.
  - RUN: WIDTH iterations.
  - FIX: sign correction and writeback.
  - IDLE again.
- IDLE, start=1 at edge E0:
  - Latch operands. For signed ops, latch absolute values plus sign flags: neg_q = rs[msb]^rt[msb], neg_r = rs[msb].
  - busy=1, counter=0, go to RUN.
- RUN, multiply: one shift-add step per cycle on a 2*WIDTH accumulator.
- RUN, divide: one restoring shift-subtract step per cycle. Quotient bits are shifted into the low half; the remainder builds in the high half.
- RUN exit: after the WIDTH-th step (edge E_WIDTH), go to FIX.
- FIX (edge E_WIDTH+1):
  - Signed MULT: negate the 64-bit magnitude when neg_q=1.
  - Signed DIV: negate the quotient when neg_q=1 and the remainder when neg_r=1.
  - Write hi/lo, busy=0, done=1, return to IDLE.
  - done drops on the following edge.
- Latency: start at E0 gives hi/lo valid and done=1 after E(WIDTH+1), i.e. edge 33 for WIDTH=32. busy is high for exactly WIDTH+1 cycles.
- start while busy: ignored, with no effect on the operation in flight.
- write_hi/write_lo:
  - Honoured only in IDLE with start=0; both may assert in the same cycle.
  - Ignored while busy.
  - When start=1 in the same IDLE cycle, start wins and the writes are dropped.
- Divide by zero (rt=0): full latency still applies. Result is hi=rs_data as latched (original signed value, not its magnitude) and lo=all ones. No exception.
- Signed overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural two's-complement wrap).
- Arithmetic:
  - All results are modulo 2^WIDTH per half.
  - The MULT product is the exact signed 2*WIDTH-bit value.
  - DIV truncates toward zero; the remainder takes the sign of the dividend.
- hi/lo hold their value at all times except on FIX, MTHI/MTLO and reset edges; they stay readable while busy (old values).

Test Plan:
- MULTU rs=0xFFFFFFFF rt=0xFFFFFFFF -> busy high for 33 cycles; done pulse after edge 33; hi=0xFFFFFFFE lo=0x00000001.
- MULT rs=0xFFFFFFFD (-3) rt=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB. Then DIV rs=0xFFFFFFF9 (-7) rt=2 -> lo=0xFFFFFFFD (-3) hi=0xFFFFFFFF (-1).
- DIVU rs=100 rt=0 -> hi=100 lo=0xFFFFFFFF after the same 33-cycle latency. DIV rs=0x80000000 rt=0xFFFFFFFF -> lo=0x80000000 hi=0.
- MULTU 6*7 started; second start (op=DIVU, rs=9 rt=3) at cycle 5 -> ignored; hi=0 lo=42; done pulses exactly once.
- MTHI rs=0x12345678 and MTLO rs=0x9ABCDEF0 in IDLE -> hi/lo updated next edge. write_hi during busy -> hi unchanged. start+write_lo together -> only the operation result lands.
- MULTU started, rst_n=0 at cycle 10 -> next edge: busy=0, done=0, hi=lo=0; no done pulse afterwards. A new start after release completes normally.

Source files
------------

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO and MTHI/MTLO writes.
// Fixed latency: WIDTH shift-add / restoring-divide steps plus one fix-up cycle.
module mult_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] rs_data,
  input  logic [WIDTH-1:0] rt_data,
  input  logic             write_hi,
  input  logic             write_lo,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc, acc_step, res;
  logic [WIDTH-1:0]   opnd_b, rs_orig;
  logic               is_div, neg_q, neg_r, dz;

  logic               sgn;
  logic [WIDTH-1:0]   rs_mag, rt_mag, quo, rem;
  logic [WIDTH:0]     mul_sum, div_rem, div_diff;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == LAST) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operand magnitudes; signed ops run unsigned and fix signs at the end.
  always_comb begin
    sgn    = ~op[0];
    rs_mag = (sgn && rs_data[WIDTH-1]) ? -rs_data : rs_data;
    rt_mag = (sgn && rt_data[WIDTH-1]) ? -rt_data : rt_data;
  end

  // One iteration: multiply adds into the upper half then shifts right;
  // divide shifts left and keeps the trial subtraction when it does not borrow.
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd_b : {WIDTH{1'b0}})};
    div_rem  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_diff = div_rem - {1'b0, opnd_b};
    if (is_div)
      acc_step = div_diff[WIDTH] ? {div_rem[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                 : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_step = {mul_sum, acc[WIDTH-1:1]};
  end

  always_comb begin
    quo = acc[WIDTH-1:0];
    rem = acc[2*WIDTH-1:WIDTH];
    if (dz)
      res = {rs_orig, {WIDTH{1'b1}}};
    else if (is_div)
      res = {(neg_r ? -rem : rem), (neg_q ? -quo : quo)};
    else
      res = neg_q ? -acc : acc;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      acc     <= '0;
      opnd_b  <= '0;
      rs_orig <= '0;
      is_div  <= 1'b0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      dz      <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            acc     <= {{WIDTH{1'b0}}, (op[1] ? rs_mag : rt_mag)};
            opnd_b  <= op[1] ? rt_mag : rs_mag;
            rs_orig <= rs_data;
            is_div  <= op[1];
            neg_q   <= sgn & (rs_data[WIDTH-1] ^ rt_data[WIDTH-1]);
            neg_r   <= sgn & rs_data[WIDTH-1];
            dz      <= op[1] & (rt_data == '0);
            cnt     <= '0;
            busy    <= 1'b1;
          end else begin
            if (write_hi) hi <= rs_data;
            if (write_lo) lo <= rs_data;
          end
        end
        RUN: begin
          acc <= acc_step;
          cnt <= cnt + 1'b1;
        end
        FIX: begin
          {hi, lo} <= res;
          busy     <= 1'b0;
          done     <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
